// File: rtl/clz_pkg.sv
// Shared constants for the leading-zero counter arbiter: op encodings,
// requester ids and the count width.
package clz_pkg;
    localparam logic [1:0] CLZ_OP_CLZ = 2'd0;
    localparam logic [1:0] CLZ_OP_CLO = 2'd1;
    localparam logic       REQ_ALU    = 1'b0;
    localparam logic       REQ_DIV    = 1'b1;
    localparam int         CLZ_CNT_W  = 6;
endpackage

// File: rtl/clz_share_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the
// shared leading-zero counter.
interface clz_share_arbiter_if #(
    parameter int TAG_W = 5
);
    import clz_pkg::*;

    logic [1:0]           i_req_valid;
    logic [1:0]           o_req_ready;
    logic [31:0]          i_req0_data;
    logic [31:0]          i_req1_data;
    logic [1:0]           i_req_op;
    logic [TAG_W-1:0]     i_req0_tag;
    logic [TAG_W-1:0]     i_req1_tag;
    logic                 i_flush;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic                 o_rsp_id;
    logic [TAG_W-1:0]     o_rsp_tag;
    logic [CLZ_CNT_W-1:0] o_rsp_count;

    modport master (
        output i_req_valid, i_req0_data, i_req1_data, i_req_op,
        output i_req0_tag, i_req1_tag, i_flush, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_count
    );

    modport slave (
        input  i_req_valid, i_req0_data, i_req1_data, i_req_op,
        input  i_req0_tag, i_req1_tag, i_flush, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_count
    );
endinterface

// File: rtl/clz_core.sv
// Purely combinational 32-bit leading-zero counter; an all-zero operand
// counts as 32.
module clz_core
    import clz_pkg::*;
(
    input  logic [31:0]          operand,
    output logic [CLZ_CNT_W-1:0] count
);
    always_comb begin
        count = CLZ_CNT_W'(32);
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i < 32; i++) begin
            if (operand[i]) begin
                count = CLZ_CNT_W'(31 - i);
            end
        end
    end
endmodule

// File: rtl/clz_share_arbiter.sv
// Shares one leading-zero counter between the ALU (port 0) and the divider
// pre-normaliser (port 1) behind a single registered result stage.
module clz_share_arbiter
    import clz_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter bit RR_EN = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    clz_share_arbiter_if.slave  bus
);
    logic                 rr_ptr_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_id_reg;
    logic [TAG_W-1:0]     rsp_tag_reg;
    logic [CLZ_CNT_W-1:0] rsp_count_reg;

    logic                 free;
    logic                 valid_alu;
    logic                 valid_div;
    logic [1:0]           grant;
    logic                 xfer;
    logic                 win_id;
    logic [31:0]          operand;
    logic [TAG_W-1:0]     win_tag;
    logic [CLZ_CNT_W-1:0] count;

    always_comb begin
        free      = ~rsp_valid_reg | bus.i_rsp_ready;
        // A flush only ever kills ALU work; the divider keeps competing.
        valid_alu = bus.i_req_valid[REQ_ALU] & ~bus.i_flush;
        valid_div = bus.i_req_valid[REQ_DIV];
        grant     = 2'b00;
        if (free && i_rst_n) begin
            if (valid_alu && valid_div) begin
                grant = (RR_EN && rr_ptr_reg) ? 2'b10 : 2'b01;
            end else begin
                grant = {valid_div, valid_alu};
            end
        end
        xfer    = |grant;
        win_id  = grant[REQ_DIV];
        operand = win_id ? bus.i_req1_data : bus.i_req0_data;
        win_tag = win_id ? bus.i_req1_tag : bus.i_req0_tag;
        // Reserved op codes fall through to plain CLZ.
        if (bus.i_req_op == CLZ_OP_CLO) begin
            operand = ~operand;
        end
    end

    clz_core u_core (
        .operand (operand),
        .count   (count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_reg    <= REQ_ALU;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_tag_reg   <= '0;
            rsp_count_reg <= '0;
        end else if (xfer) begin
            rr_ptr_reg    <= ~win_id;
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= win_id;
            rsp_tag_reg   <= win_tag;
            rsp_count_reg <= count;
        end else if (rsp_valid_reg && bus.i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end else if (rsp_valid_reg && bus.i_flush && rsp_id_reg == REQ_ALU) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_rsp_valid = rsp_valid_reg;
    assign bus.o_rsp_id    = rsp_id_reg;
    assign bus.o_rsp_tag   = rsp_tag_reg;
    assign bus.o_rsp_count = rsp_count_reg;
endmodule

// File: tb/tb_clz_share_arbiter.sv
// Directed bench for clz_share_arbiter: a round-robin instance and a
// fixed-priority instance driven with identical stimulus.
module tb_clz_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] d0, d1;
    logic [1:0]  op;
    logic [4:0]  tag0, tag1;
    logic        flush;
    logic        rsp_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clz_share_arbiter_if #(.TAG_W(5)) bus_rr ();
    clz_share_arbiter_if #(.TAG_W(5)) bus_fx ();

    assign bus_rr.i_req_valid = req_valid;
    assign bus_rr.i_req0_data = d0;
    assign bus_rr.i_req1_data = d1;
    assign bus_rr.i_req_op    = op;
    assign bus_rr.i_req0_tag  = tag0;
    assign bus_rr.i_req1_tag  = tag1;
    assign bus_rr.i_flush     = flush;
    assign bus_rr.i_rsp_ready = rsp_ready;
    assign bus_fx.i_req_valid = req_valid;
    assign bus_fx.i_req0_data = d0;
    assign bus_fx.i_req1_data = d1;
    assign bus_fx.i_req_op    = op;
    assign bus_fx.i_req0_tag  = tag0;
    assign bus_fx.i_req1_tag  = tag1;
    assign bus_fx.i_flush     = flush;
    assign bus_fx.i_rsp_ready = rsp_ready;

    clz_share_arbiter #(.TAG_W(5), .RR_EN(1'b1)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_rr)
    );

    clz_share_arbiter #(.TAG_W(5), .RR_EN(1'b0)) u_fix (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_fx)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string name, input logic v, input logic id,
                             input logic [4:0] tg, input logic [5:0] cnt);
        check({name, ".valid"}, 32'(bus_rr.o_rsp_valid), 32'(v));
        check({name, ".id"},    32'(bus_rr.o_rsp_id),    32'(id));
        check({name, ".tag"},   32'(bus_rr.o_rsp_tag),   32'(tg));
        check({name, ".count"}, 32'(bus_rr.o_rsp_count), 32'(cnt));
        $display("[TB] %s valid=%0d id=%0d tag=%0d count=%0d", name,
                 bus_rr.o_rsp_valid, bus_rr.o_rsp_id, bus_rr.o_rsp_tag, bus_rr.o_rsp_count);
    endtask

    logic [31:0] bnd_data [6];
    logic [1:0]  bnd_op   [6];
    logic [5:0]  bnd_cnt  [6];
    logic [1:0]  rr_grant [4];

    initial begin
        bnd_data = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFF0_0000, 32'h0000_0001, 32'h0000_0100};
        bnd_op   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
        bnd_cnt  = '{6'd32, 6'd0, 6'd32, 6'd12, 6'd31, 6'd23};
        rr_grant = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset: outputs clear and ready stays low even with requests pending.
        rst_n = 1'b0; req_valid = 2'b11; d0 = '0; d1 = '0; op = 2'd0;
        tag0 = '0; tag1 = '0; flush = 1'b0; rsp_ready = 1'b1;
        tick(); tick();
        check("reset.ready", 32'(bus_rr.o_req_ready), 32'(2'b00));
        check_rsp("reset", 1'b0, 1'b0, 5'd0, 6'd0);

        // Single request on port 0.
        rst_n = 1'b1; req_valid = 2'b01; d0 = 32'h0000_8000; tag0 = 5'd7;
        #1 check("single.ready", 32'(bus_rr.o_req_ready), 32'(2'b01));
        tick();
        check_rsp("single", 1'b1, 1'b0, 5'd7, 6'd16);

        // Boundary counts, back-to-back at full throughput.
        for (int i = 0; i < 6; i++) begin
            d0 = bnd_data[i]; op = bnd_op[i]; tag0 = 5'(i);
            #1 check($sformatf("bnd%0d.ready", i), 32'(bus_rr.o_req_ready), 32'(2'b01));
            tick();
            check_rsp($sformatf("bnd%0d", i), 1'b1, 1'b0, 5'(i), bnd_cnt[i]);
        end
        op = 2'd0; req_valid = 2'b00;
        tick();
        check("drain.valid", 32'(bus_rr.o_rsp_valid), 32'(1'b0));

        // Port 1 alone; leaves the pointer favouring port 0.
        req_valid = 2'b10; d1 = 32'h0001_0000; tag1 = 5'd3;
        #1 check("p1.ready", 32'(bus_rr.o_req_ready), 32'(2'b10));
        tick();
        check_rsp("p1", 1'b1, 1'b1, 5'd3, 6'd15);

        // Both ports valid: RR alternates, fixed priority starves port 1.
        req_valid = 2'b11; d0 = 32'h0000_00FF; d1 = 32'h0FFF_FFFF; tag0 = 5'd1; tag1 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("rr%0d.ready", i), 32'(bus_rr.o_req_ready), 32'(rr_grant[i]));
            check($sformatf("fx%0d.ready", i), 32'(bus_fx.o_req_ready), 32'(2'b01));
            tick();
            if (rr_grant[i] == 2'b01) check_rsp($sformatf("rr%0d", i), 1'b1, 1'b0, 5'd1, 6'd24);
            else                      check_rsp($sformatf("rr%0d", i), 1'b1, 1'b1, 5'd2, 6'd4);
            check($sformatf("fx%0d.id", i), 32'(bus_fx.o_rsp_id), 32'(1'b0));
        end

        // Back-pressure: port-1 result held, nothing accepted, outputs frozen.
        rsp_ready = 1'b0;
        #1 check("bp.ready", 32'(bus_rr.o_req_ready), 32'(2'b00));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.hold_ready", 32'(bus_rr.o_req_ready), 32'(2'b00));
            check_rsp($sformatf("bp%0d", i), 1'b1, 1'b1, 5'd2, 6'd4);
        end
        rsp_ready = 1'b1;
        #1 check("bp.release_ready", 32'(bus_rr.o_req_ready), 32'(2'b01));
        tick();
        check_rsp("bp.next", 1'b1, 1'b0, 5'd1, 6'd24);
        req_valid = 2'b00;
        tick();
        check("bp.drain", 32'(bus_rr.o_rsp_valid), 32'(1'b0));

        // Flush kills a held port-0 result.
        req_valid = 2'b01; d0 = 32'h0000_0001; tag0 = 5'd9; rsp_ready = 1'b0;
        #1 check("fl.ready0", 32'(bus_rr.o_req_ready), 32'(2'b01));
        tick();
        check_rsp("fl.held0", 1'b1, 1'b0, 5'd9, 6'd31);
        req_valid = 2'b00; flush = 1'b1;
        tick();
        check("fl.kill", 32'(bus_rr.o_rsp_valid), 32'(1'b0));

        // Flush masks port 0 even when the slot is free.
        req_valid = 2'b01;
        #1 check("fl.mask0", 32'(bus_rr.o_req_ready), 32'(2'b00));
        tick();
        check("fl.nodata", 32'(bus_rr.o_rsp_valid), 32'(1'b0));

        // Port 1 still granted under flush, and its held result survives.
        req_valid = 2'b11; d1 = 32'h0000_0F00; tag1 = 5'd4;
        #1 check("fl.ready1", 32'(bus_rr.o_req_ready), 32'(2'b10));
        tick();
        check_rsp("fl.load1", 1'b1, 1'b1, 5'd4, 6'd20);
        req_valid = 2'b00;
        tick();
        check_rsp("fl.keep1", 1'b1, 1'b1, 5'd4, 6'd20);
        flush = 1'b0; rsp_ready = 1'b1;
        tick();
        check("fl.consumed", 32'(bus_rr.o_rsp_valid), 32'(1'b0));

        // Reset mid-transfer drops the held result and re-favours port 0.
        req_valid = 2'b01; d0 = 32'h0000_0010; tag0 = 5'd5; rsp_ready = 1'b0;
        tick();
        check_rsp("mid.held", 1'b1, 1'b0, 5'd5, 6'd27);
        req_valid = 2'b00; rst_n = 1'b0;
        tick();
        check_rsp("mid.reset", 1'b0, 1'b0, 5'd0, 6'd0);
        rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        #1 check("mid.ready", 32'(bus_rr.o_req_ready), 32'(2'b01));
        tick();
        check_rsp("mid.first", 1'b1, 1'b0, 5'd5, 6'd27);
        req_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clz_share_arbiter.md
Name: clz_share_arbiter

Overview:
- Shares one combinational 32-bit leading-zero counter between two requesters: port 0 is the EX-stage ALU (CLZ/CLO instructions), port 1 is the divider pre-normalisation path.
- Round-robin arbitration with a valid/ready handshake on each request port, one registered result stage with a valid/ready handshake, and a flush that kills in-flight ALU work.
- CLO is performed by inverting the operand before counting.

Parameters:
- TAG_W, 5, width of the opaque requester tag returned with the result (e.g. destination register index).
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, with port 0 winning.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  2  per-port request valid; bit n = port n.
- o_req_ready  out  2  per-port accept; at most one bit high per cycle.
- i_req0_data  in  32  port 0 operand.
- i_req1_data  in  32  port 1 operand.
- i_req_op  in  2  per-port op: 0 = CLZ, 1 = CLO.
- i_req0_tag  in  TAG_W  port 0 tag.
- i_req1_tag  in  TAG_W  port 1 tag.
- i_flush  in  1  pipeline flush: kills port-0 work.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  consumer accepts result.
- o_rsp_id  out  1  port that issued the result.
- o_rsp_tag  out  TAG_W  tag of that request.
- o_rsp_count  out  6  count, 0..32.

Behaviour:
- Reset: i_rst_n sampled low at a rising edge clears o_rsp_valid, o_rsp_id, o_rsp_tag and o_rsp_count to 0, and sets the round-robin pointer to 0 (port 0 favoured). o_req_ready is combinationally 0 while i_rst_n is low. Reset mid-transfer drops the held result with no response.
- Slot free: free = ~o_rsp_valid | i_rsp_ready.
- Grant, computed combinationally every cycle, only when free is 1:
  - If only one port is valid (after masking), grant it.
  - If both are valid: RR_EN=1 grants the port the pointer favours; RR_EN=0 grants port 0.
- o_req_ready is the one-hot grant; it is 0 when free=0 or nothing is granted. Transfer on a port = valid & ready.
- Round-robin pointer: after a transfer from port n, the pointer favours port ~n. With no transfer the pointer holds. Consequence: with both ports continuously valid and no back-pressure, grants alternate 0,1,0,1.
- Datapath:
  - Operand is data when op=0 and ~data when op=1; it feeds the counter combinationally.
  - Counter result: 32 for an all-zero operand; otherwise the number of zeros above the leading 1.
  - The result stage loads count, id and tag on the transfer edge. Latency is 1 cycle from accept to o_rsp_valid.
- Result stage:
  - Loads on transfer.
  - Clears o_rsp_valid when the result is consumed (o_rsp_valid & i_rsp_ready) with no new transfer.
  - Otherwise holds all outputs stable.
  - Full throughput: one result per cycle while i_rsp_ready=1.
- Back-pressure: while o_rsp_valid=1 and i_rsp_ready=0, o_req_ready=0 and the outputs are frozen.
- Flush (i_flush=1 at an edge):
  - Port 0 is masked out of arbitration that cycle, so o_req_ready[0]=0.
  - A held result with o_rsp_id=0 is invalidated at the edge.
  - Port 1 is unaffected: it may still be granted and loaded in the same cycle, and a held port-1 result survives.
- Simultaneous consume and load in the same edge: the new result replaces the old; no bubble.
- Op values 2 and 3 are reserved and behave as CLZ.

Decomposition:
- Package clz_pkg holds:
  - localparams CLZ_OP_CLZ=2'd0 and CLZ_OP_CLO=2'd1.
  - REQ_ALU=1'b0 and REQ_DIV=1'b1.
  - CLZ_CNT_W=6.
- One natural sub-module: clz_core, a purely combinational 32-bit leading-zero counter with a 6-bit count output; it is instantiated once.
- Arbitration, pointer, flush masking and the result register stay in clz_share_arbiter.

Test Plan:
- Reset and single request: hold i_rst_n=0 for 2 cycles and check all outputs are 0. Then port 0 sends data=32'h0000_8000, op=CLZ, tag=5'd7 → ready[0] in the same cycle; next cycle rsp_valid=1, count=16, id=0, tag=7.
- Boundary counts: CLZ of 32'h0 → 32; CLZ of 32'h8000_0000 → 0; CLO of 32'hFFFF_FFFF → 32; CLO of 32'hFFF0_0000 → 12; CLZ of 32'h1 → 31.
- Round-robin: both ports valid for 4 cycles with rsp_ready=1 → grant sequence 0,1,0,1 and results in matching order. With RR_EN=0 → 0,0,0,0 and port 1 is starved.
- Back-pressure: a result is held with rsp_ready=0 for 3 cycles while both ports are valid → o_req_ready=0 and outputs stable. When rsp_ready rises, the next grant loads in that cycle with no lost or duplicated result.
- Flush: a held port-0 result with i_flush=1 → rsp_valid drops next cycle. Port 0 valid with i_flush=1 → not granted. A held port-1 result with flush → still delivered.
- Reset mid-operation: a result is held with rsp_ready=0, then i_rst_n=0 for 1 cycle → rsp_valid=0 and the pointer is back to 0. Next, both ports valid → port 0 is granted first.
